// File: rtl/divider_pkg.sv
// Shared constants and helpers for the clock-enable divider.
package divider_pkg;

  localparam int unsigned DIV_N_DEFAULT    = 50_000_000;
  localparam int unsigned TEST_DIV_DEFAULT = 4;

  // Counter width able to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input longint unsigned n);
    if (n <= 64'd2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/divider_counter.sv
// Mod-L counter: counts 0..last, wraps to 0, with synchronous clear.
// tc flags the terminal count; any value at or above last is terminal,
// so a shrink of the limit can never strand the counter above it.
module divider_counter
  import divider_pkg::*;
#(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [CW-1:0] last,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Terminal detect on the registered count.
  always_comb begin
    tc = (count_q >= last);
  end

  // Next count: wrap at terminal, otherwise increment.
  always_comb begin
    count_d = count_q + 1'b1;
    if (tc) begin
      count_d = '0;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/divider.sv
// Clock-enable generator: one-cycle ena pulse every L div_clk edges, where
// L is TEST_DIV in test mode (testn=0) and DIV_N in normal mode (testn=1).
// A change of testn restarts the period; reset aborts it.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned DIV_N    = DIV_N_DEFAULT,
  parameter int unsigned TEST_DIV = TEST_DIV_DEFAULT
) (
  input  logic div_clk,
  input  logic reset,
  input  logic testn,
  output logic ena
);

  localparam int CW = cnt_width(64'(DIV_N));
  localparam logic [CW-1:0] LAST_TEST = CW'(TEST_DIV - 1);
  localparam logic [CW-1:0] LAST_NORM = CW'(DIV_N - 1);

  // Illegal ratios are rejected while elaborating.
  if (TEST_DIV < 2 || DIV_N < 2 || TEST_DIV > DIV_N) begin : g_bad_params
    $error("divider: need 2 <= TEST_DIV <= DIV_N");
  end

  logic          mode_q;
  logic          mode_d;
  logic          ena_q;
  logic          ena_d;
  logic          mode_chg;
  logic          clr;
  logic          tc;
  logic [CW-1:0] last;

  // Mode tracking, restart conditions and the next pulse value.
  always_comb begin
    mode_chg = (testn != mode_q);
    clr      = reset | mode_chg;
    last     = mode_q ? LAST_NORM : LAST_TEST;
    mode_d   = testn;
    ena_d    = tc & ~clr;
  end

  divider_counter #(
    .CW(CW)
  ) u_counter (
    .clk  (div_clk),
    .clr  (clr),
    .last (last),
    .tc   (tc)
  );

  // Mode and output registers; reset takes priority over everything.
  always_ff @(posedge div_clk) begin
    if (reset) begin
      mode_q <= testn;
      ena_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      ena_q  <= ena_d;
    end
  end

  assign ena = ena_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider with DIV_N=10, TEST_DIV=4.
module tb_divider;

  localparam int N_NORM = 10;
  localparam int N_TEST = 4;

  logic div_clk;
  logic reset;
  logic testn;
  logic ena;

  int checks;
  int errors;
  int edge_n;

  divider #(
    .DIV_N    (N_NORM),
    .TEST_DIV (N_TEST)
  ) dut (
    .div_clk (div_clk),
    .reset   (reset),
    .testn   (testn),
    .ena     (ena)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge div_clk);
    #1;
    edge_n++;
  endtask

  // Run n edges; ena expected high only after edges that are multiples of l.
  task automatic run_expect(input string tag, input int n, input int l);
    for (int i = 1; i <= n; i++) begin
      tick();
      check(tag, {31'd0, ena}, (i % l == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic do_reset(input logic mode, input int n);
    testn = mode;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("reset_ena", {31'd0, ena}, 32'd0);
    end
    reset = 1'b0;
  endtask

  int cur_l;
  int last_evt;
  logic prev_ena;
  logic tb_mode;
  int pulses;

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    reset  = 1'b1;
    testn  = 1'b0;

    // Test mode from reset: pulses after edges 4, 8, 12.
    do_reset(1'b0, 3);
    run_expect("test_mode", 12, N_TEST);

    // Normal mode from reset: pulses after edges 10, 20, 30.
    do_reset(1'b1, 3);
    run_expect("norm_mode", 30, N_NORM);

    // Switch to normal at edge 6: pulses after 16 and 26.
    do_reset(1'b0, 2);
    run_expect("pre_switch", 5, N_TEST);
    testn = 1'b1;
    tick();
    check("switch_edge", {31'd0, ena}, 32'd0);
    run_expect("post_switch", 20, N_NORM);

    // Switch on the terminal edge: no pulse, restart in test mode.
    run_expect("pre_tc_switch", 9, N_NORM);
    testn = 1'b0;
    tick();
    check("tc_switch_edge", {31'd0, ena}, 32'd0);
    run_expect("post_tc_switch", 8, N_TEST);

    // Reset at count=2 in normal mode aborts the period.
    testn = 1'b1;
    tick();
    check("to_norm_edge", {31'd0, ena}, 32'd0);
    run_expect("pre_mid_reset", 2, N_NORM);
    reset = 1'b1;
    tick();
    check("mid_reset", {31'd0, ena}, 32'd0);
    reset = 1'b0;
    run_expect("after_mid_reset", 10, N_NORM);

    // Reset on the terminal edge suppresses that pulse.
    run_expect("pre_tc_reset", 9, N_NORM);
    reset = 1'b1;
    tick();
    check("tc_reset", {31'd0, ena}, 32'd0);
    reset = 1'b0;
    run_expect("after_tc_reset", 10, N_NORM);

    // Long run with periodic mode toggles: width and spacing checks.
    tb_mode  = 1'b1;
    cur_l    = N_NORM;
    last_evt = 0;
    prev_ena = ena;
    pulses   = 0;
    for (int c = 1; c <= 1000; c++) begin
      logic chg;
      chg = 1'b0;
      if (c % 137 == 0) begin
        testn = ~tb_mode;
        chg   = 1'b1;
      end
      tick();
      if (chg) begin
        check("long_chg_edge", {31'd0, ena}, 32'd0);
        tb_mode  = testn;
        cur_l    = tb_mode ? N_NORM : N_TEST;
        last_evt = c;
      end else if (ena) begin
        pulses++;
        check("long_width", {31'd0, prev_ena}, 32'd0);
        check("long_spacing", c - last_evt, cur_l);
        last_evt = c;
      end else if (c - last_evt >= cur_l) begin
        check("long_missing", c - last_evt, cur_l - 1);
        last_evt = c;
      end
      prev_ena = ena;
    end
    check("long_pulses_seen", {31'd0, (pulses > 50)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DIV_N, default 50_000_000, normal-mode divide ratio; legal range 2..2^31-1.
REQ-002 Parameter TEST_DIV, default 4, test-mode divide ratio; legal range 2..DIV_N.
REQ-003 div_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the div_clk rising edge.
REQ-005 testn  input  1  mode select, active-low: 0 = test mode (divide by TEST_DIV), 1 = normal mode (divide by DIV_N); synchronous to div_clk.
REQ-006 ena  output  1  registered clock-enable pulse, high for exactly one div_clk cycle per period.

Function
REQ-007 The block SHALL hold a counter of width max(1,$clog2(DIV_N)) and a registered mode bit mode_q (copy of testn).
REQ-008 Active limit L SHALL be TEST_DIV when mode_q=0 and DIV_N when mode_q=1.
REQ-009 On each rising edge with reset=0 and testn==mode_q: if count==L-1 then count<=0 and ena<=1, else count<=count+1 and ena<=0.
REQ-010 ena SHALL therefore go high after every L-th edge and stay high for exactly one cycle; duty = 1/L; no combinational path from any input to ena.
REQ-011 First pulse after reset release SHALL occur after the L-th rising edge with reset=0 (ena high during cycle L+1).
REQ-012 Mode change: on an edge where testn!=mode_q (reset=0), the block SHALL set mode_q<=testn, count<=0, ena<=0; the next pulse follows L_new edges later.
REQ-013 A pulse already high SHALL drop on the mode-change edge; no truncated or doubled pulse SHALL be produced.
REQ-014 If count>=L-1 in any state (e.g. after a limit shrink), the block SHALL treat it as terminal: pulse and wrap to 0.
REQ-015 Counter wrap SHALL never exceed L-1; arithmetic is unsigned, no overflow past DIV_N-1.

Reset
REQ-016 With reset=1 at a rising edge: count<=0, ena<=0, mode_q<=testn (no mode-change restart after release).
REQ-017 Reset SHALL take priority over mode change and terminal count; reset mid-period SHALL abort the period with no pulse.
REQ-018 ena SHALL be 0 from the first reset edge until the L-th edge after release.

Structure
REQ-019 A shared package divider_pkg SHALL hold DIV_N_DEFAULT, TEST_DIV_DEFAULT and the counter-width function.
REQ-020 One sub-module divider_counter (mod-L counter with synchronous clear, terminal-count output) is natural; divider wraps it with mode register and output register.
REQ-021 Parameter legality SHALL be checked at elaboration (error if TEST_DIV<2, DIV_N<2 or TEST_DIV>DIV_N).

Verification (bench uses DIV_N=10, TEST_DIV=4)
REQ-022 reset=1 for 3 edges, testn=0, release -> ena=0 for edges 1-3, ena=1 only after edge 4, then every 4 edges (8, 12, ...).
REQ-023 testn=1 from reset -> ena pulses after edges 10, 20, 30; each pulse exactly one cycle wide.
REQ-024 test mode running, switch testn 0->1 at edge 6 after release -> ena=0 at edge 6, next pulse after edge 16, then 26.
REQ-025 switch testn on the same edge ena would assert (terminal count) -> ena stays 0, counter restarts, next pulse L_new edges later.
REQ-026 assert reset at count=2 in normal mode -> ena=0, count=0; after release first pulse after edge 10.
REQ-027 checker: over 1000 cycles, ena never high two consecutive cycles and pulse spacing always equals the active L.
